// File: rtl/stopwatch_bcd.sv
// BCD stopwatch (MM:SS.cc) advanced by rising edges of an external tick, with debounced start/stop and clear keys.
// Optional lap/freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       key_startstop_n,
  input  logic       key_clear_n,
`ifdef STOPWATCH_LAP_EN
  input  logic       key_lap_n,
  output logic       lap_active,
`endif
  output logic       running,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       tick_seen,
  output logic       overflow
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  // Per-digit terminal values, packed {min_t, min_u, sec_t, sec_u, cs_t, cs_u}.
  localparam logic [23:0] DIGIT_MAX = 24'h595999;

`ifdef STOPWATCH_LAP_EN
  localparam int NKEYS = 3;
  logic [NKEYS-1:0] key_raw;
  assign key_raw = {key_lap_n, key_clear_n, key_startstop_n};
`else
  localparam int NKEYS = 2;
  logic [NKEYS-1:0] key_raw;
  assign key_raw = {key_clear_n, key_startstop_n};
`endif

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state_reg, state_next;
  logic [NKEYS-1:0] key_press;
  logic [SYNC_STAGES-1:0] tick_sync_reg;
  logic             tick_prev_reg;
  logic             tick_edge;
  logic             tick_seen_reg;
  logic [23:0]      cnt_reg, cnt_next;
  logic             overflow_reg, overflow_next;
  logic             do_clear;
  logic             carry;
  logic [23:0]      display;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   accepted_reg;
      logic [DBW-1:0]         cnt_reg;
      logic                   level;

      assign level = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg     <= '1;
          accepted_reg <= 1'b1;
          cnt_reg      <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_raw[gi]};
          if (level == accepted_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            accepted_reg <= level;
            cnt_reg      <= '0;
          end else begin
            cnt_reg <= cnt_reg + DBW'(1);
          end
        end
      end

      // Pulses on the cycle the accepted level falls; releases produce nothing.
      assign key_press[gi] = (level != accepted_reg) && (cnt_reg == DB_LAST) && !level;
    end
  endgenerate

  assign tick_edge = tick_sync_reg[SYNC_STAGES-1] & ~tick_prev_reg;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync_reg <= '0;
      tick_prev_reg <= 1'b0;
      tick_seen_reg <= 1'b0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      tick_sync_reg <= {tick_sync_reg[SYNC_STAGES-2:0], tick_in};
      tick_prev_reg <= tick_sync_reg[SYNC_STAGES-1];
      tick_seen_reg <= tick_edge;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Clear wins over start/stop in the same cycle, but only outside RUN.
  always_comb begin
    state_next = state_reg;
    do_clear   = 1'b0;
    if (key_press[1] && (state_reg != RUN)) begin
      state_next = IDLE;
      do_clear   = 1'b1;
    end else if (key_press[0]) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Ripple carry across digits; any out-of-range nibble is treated as terminal and wraps.
  always_comb begin
    cnt_next      = cnt_reg;
    overflow_next = overflow_reg;
    carry         = 1'b0;
    if (do_clear) begin
      cnt_next      = '0;
      overflow_next = 1'b0;
    end else if (tick_edge && (state_reg == RUN)) begin
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (carry) begin
          if (cnt_reg[4*i +: 4] >= DIGIT_MAX[4*i +: 4]) begin
            cnt_next[4*i +: 4] = 4'd0;
          end else begin
            cnt_next[4*i +: 4] = cnt_reg[4*i +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end
      end
      if (carry) overflow_next = 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_reg;
  logic [23:0] frozen_reg;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lap_reg    <= 1'b0;
      frozen_reg <= '0;
    end else if (do_clear) begin
      lap_reg <= 1'b0;
    end else if (key_press[2] && (state_reg != IDLE)) begin
      if (lap_reg) begin
        lap_reg <= 1'b0;
      end else if (state_reg == RUN) begin
        lap_reg    <= 1'b1;
        frozen_reg <= cnt_reg;
      end
    end
  end

  assign lap_active = lap_reg;
  assign display    = lap_reg ? frozen_reg : cnt_reg;
`else
  assign display = cnt_reg;
`endif

  assign running   = (state_reg == RUN);
  assign tick_seen = tick_seen_reg;
  assign overflow  = overflow_reg;
  assign cs_bcd    = display[7:0];
  assign sec_bcd   = display[15:8];
  assign min_bcd   = display[23:16];

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: scoreboard of expected snapshots, checked with immediate assertions.
// Lap steps are included when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_bcd;
  localparam int DB = 4;

  logic       clkin = 1'b0;
  logic       rst_n, tick_in, key_startstop_n, key_clear_n;
  logic       running, tick_seen, overflow, lap_active;
  logic [7:0] cs_bcd, sec_bcd, min_bcd;
`ifdef STOPWATCH_LAP_EN
  logic       key_lap_n;
`endif

  always #5 clkin = ~clkin;

  stopwatch_bcd #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(2)) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .tick_in(tick_in),
    .key_startstop_n(key_startstop_n),
    .key_clear_n(key_clear_n),
`ifdef STOPWATCH_LAP_EN
    .key_lap_n(key_lap_n),
    .lap_active(lap_active),
`endif
    .running(running),
    .cs_bcd(cs_bcd),
    .sec_bcd(sec_bcd),
    .min_bcd(min_bcd),
    .tick_seen(tick_seen),
    .overflow(overflow)
  );
`ifndef STOPWATCH_LAP_EN
  assign lap_active = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int seen_cnt = 0;
  int seen_base;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Reference model state
  int mt = 0;
  int frozen_t = 0;
  bit exp_run = 0, exp_ovf = 0, exp_lap = 0;

  always @(negedge clkin) if (tick_seen === 1'b1) seen_cnt <= seen_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] to_bcd(input int t);
    int mm, ss, cc;
    mm = (t / 6000) % 60;
    ss = (t / 100) % 60;
    cc = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic int disp();
    return exp_lap ? frozen_t : mt;
  endfunction

  function automatic logic [31:0] mk(input int t);
    return {5'd0, exp_lap, exp_run, exp_ovf, to_bcd(t)};
  endfunction

  function automatic logic [31:0] snap();
    return {5'd0, lap_active, running, overflow, min_bcd, sec_bcd, cs_bcd};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic model_tick();
    if (exp_run) begin
      mt++;
      if (mt == 360000) begin
        mt = 0;
        exp_ovf = 1;
      end
    end
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) model_tick();
    sb_push(tag, mk(disp()));
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1; step(10);
      tick_in = 1'b0; step(10);
    end
    sb_check(snap());
  endtask

  task automatic press(input logic ss, input logic clr, input string tag);
    sb_push(tag, mk(disp()));
    key_startstop_n = ~ss;
    key_clear_n     = ~clr;
    step(10);
    key_startstop_n = 1'b1;
    key_clear_n     = 1'b1;
    step(12);
    sb_check(snap());
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic lap_press(input string tag);
    sb_push(tag, mk(disp()));
    key_lap_n = 1'b0; step(10);
    key_lap_n = 1'b1; step(12);
    sb_check(snap());
  endtask
`endif

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; key_startstop_n = 1'b1; key_clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    key_lap_n = 1'b1;
`endif
    step(3);
    sb_push("reset_state", mk(0));
    sb_push("reset_tick_seen", 32'd0);
    sb_check(snap());
    sb_check({31'd0, tick_seen});
    rst_n = 1'b1;
    step(2);

    // Run to 00:01.37, then reset asynchronously
    exp_run = 1; press(1'b1, 1'b0, "start_from_idle");
    ticks(137, "run_137");
    @(posedge clkin); #1;
    rst_n = 1'b0;
    mt = 0; exp_run = 0; exp_ovf = 0; exp_lap = 0;
    sb_push("reset_async", mk(0));
    #2;
    sb_check(snap());
    step(2);
    rst_n = 1'b1;
    step(2);
    ticks(1, "idle_tick_ignored");

    // Start, first tick latency, then 150 ticks total
    exp_run = 1; press(1'b1, 1'b0, "start_run");
    sb_push("latency_pre", mk(mt));
    model_tick();
    sb_push("latency_post", mk(mt));
    sb_push("tick_seen_pulse", 32'd1);
    seen_base = seen_cnt;
    tick_in = 1'b1; step(2);
    sb_check(snap());
    step(1);
    sb_check(snap());
    sb_check({31'd0, tick_seen});
    step(7); tick_in = 1'b0; step(10);
    ticks(149, "run_150");
    sb_push("tick_seen_count", 32'd150);
    sb_check(32'(seen_cnt - seen_base));

    // Bouncing key: exactly one press (RUN -> PAUSE)
    exp_run = 0;
    sb_push("bounce_one_press", mk(disp()));
    key_startstop_n = 1'b0; step(2);
    key_startstop_n = 1'b1; step(2);
    key_startstop_n = 1'b0; step(2);
    key_startstop_n = 1'b1; step(2);
    key_startstop_n = 1'b0; step(10);
    key_startstop_n = 1'b1; step(12);
    sb_check(snap());
    ticks(1, "pause_tick_ignored");

    // Simultaneous clear+start in PAUSE, then in RUN
    mt = 0; press(1'b1, 1'b1, "clear_start_pause");
    exp_run = 1; press(1'b1, 1'b0, "start_again");
    ticks(5, "run_5");
    exp_run = 0; press(1'b1, 1'b1, "clear_start_run");

    // Preload 59:59.98 while paused, wrap into overflow
    force dut.cnt_reg = 24'h595998;
    step(2);
    release dut.cnt_reg;
    mt = 359998;
    exp_run = 1; press(1'b1, 1'b0, "start_preload");
    ticks(1, "run_595999");
    ticks(1, "wrap_overflow");
    ticks(1, "after_wrap");
    press(1'b0, 1'b1, "clear_in_run_ignored");
    exp_run = 0; press(1'b1, 1'b0, "pause_keeps_ovf");
    mt = 0; exp_ovf = 0; press(1'b0, 1'b1, "clear_ovf");

`ifdef STOPWATCH_LAP_EN
    lap_press("lap_idle_ignored");
    exp_run = 1; press(1'b1, 1'b0, "start_lap");
    ticks(20, "run_20");
    frozen_t = mt; exp_lap = 1; lap_press("lap_freeze");
    ticks(30, "lap_hold");
    exp_lap = 0; lap_press("lap_release");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
